// File: rtl/cmp_pkg.sv
// Shared types and helpers for the sliced magnitude comparator.
// Flag encoding is {gt, eq, lt}; exactly one bit set for a valid result.
package cmp_pkg;

    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } cmp_flags_t;

    localparam cmp_flags_t CMP_GT   = 3'b100;
    localparam cmp_flags_t CMP_EQ   = 3'b010;
    localparam cmp_flags_t CMP_LT   = 3'b001;
    localparam cmp_flags_t CMP_NONE = 3'b000;

    function automatic int nch(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/comparator_slice.sv
// Combinational CHUNK-bit three-way compare of one operand slice.
// No state and no handshake; the parent pipeline registers the result.
module comparator_slice
    import cmp_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    output cmp_flags_t       o_flags
);

    always_comb begin
        if (i_a > i_b)       o_flags = CMP_GT;
        else if (i_a == i_b) o_flags = CMP_EQ;
        else                 o_flags = CMP_LT;
    end

endmodule

// File: rtl/comparator_pipe.sv
// Two-stage sliced three-way comparator, 2-cycle latency, valid/ready on both sides (no skid);
// in_ready = !s1_valid | !out_valid | out_ready. Define CMP_SIGNED_EN for the is_signed port.
module comparator_pipe
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef CMP_SIGNED_EN
    input  logic             is_signed,
`endif
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             a_gt_b,
    output logic             a_eq_b,
    output logic             a_lt_b,
    output logic [TAG_W-1:0] out_tag
);

    localparam int NCH = nch(WIDTH, CHUNK);

    generate
        if ((WIDTH % CHUNK) != 0 || NCH < 1) begin : g_bad_cfg
            $error("comparator_pipe: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;

`ifdef CMP_SIGNED_EN
    // Flipping the sign bit maps two's-complement order onto unsigned order.
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};
    assign w_a = a ^ ({WIDTH{is_signed}} & MSB_MASK);
    assign w_b = b ^ ({WIDTH{is_signed}} & MSB_MASK);
`else
    assign w_a = a;
    assign w_b = b;
`endif

    cmp_flags_t w_slice [NCH];

    generate
        for (genvar g = 0; g < NCH; g++) begin : g_slice
            comparator_slice #(.CHUNK(CHUNK)) u_slice (
                .i_a     (w_a[g*CHUNK +: CHUNK]),
                .i_b     (w_b[g*CHUNK +: CHUNK]),
                .o_flags (w_slice[g])
            );
        end
    endgenerate

    logic             r_s1_valid;
    logic [TAG_W-1:0] r_s1_tag;
    cmp_flags_t       r_s1_flags [NCH];

    logic             r_out_valid;
    logic [TAG_W-1:0] r_out_tag;
    cmp_flags_t       r_out_flags;

    logic             w_s2_ready;
    cmp_flags_t       w_merge;

    assign w_s2_ready = !r_out_valid || out_ready;
    assign in_ready   = !r_s1_valid || w_s2_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_tag   <= '0;
            for (int k = 0; k < NCH; k++) r_s1_flags[k] <= CMP_NONE;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            r_s1_tag   <= in_tag;
            for (int k = 0; k < NCH; k++) r_s1_flags[k] <= w_slice[k];
        end
    end

    // The most significant unequal slice decides; lower slices only matter while all above tie.
    always_comb begin
        logic w_eq_run;
        w_merge  = CMP_NONE;
        w_eq_run = 1'b1;
        for (int k = NCH - 1; k >= 0; k--) begin
            w_merge.gt = w_merge.gt | (w_eq_run & r_s1_flags[k].gt);
            w_merge.lt = w_merge.lt | (w_eq_run & r_s1_flags[k].lt);
            w_eq_run   = w_eq_run & r_s1_flags[k].eq;
        end
        w_merge.eq = w_eq_run;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_flags <= CMP_NONE;
            r_out_tag   <= '0;
        end else if (w_s2_ready) begin
            r_out_valid <= r_s1_valid;
            r_out_flags <= r_s1_valid ? w_merge : CMP_NONE;
            r_out_tag   <= r_s1_valid ? r_s1_tag : '0;
        end
    end

    assign out_valid = r_out_valid;
    assign a_gt_b    = r_out_flags.gt;
    assign a_eq_b    = r_out_flags.eq;
    assign a_lt_b    = r_out_flags.lt;
    assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_comparator_pipe.sv
// Directed bench for comparator_pipe: hand-computed flags per vector, in-order scoreboard on the
// output handshake, plus reset, latency, backpressure, full-rate and mid-stream reset checks.
module tb_comparator_pipe;
    import cmp_pkg::*;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [31:0] a         = '0;
    logic [31:0] b         = '0;
`ifdef CMP_SIGNED_EN
    logic        is_signed = 1'b0;
`endif
    logic [3:0]  in_tag    = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        a_gt_b;
    logic        a_eq_b;
    logic        a_lt_b;
    logic [3:0]  out_tag;

    typedef struct {
        logic [2:0] f;
        logic [3:0] t;
    } exp_t;

    exp_t exp_q [$];
    exp_t mon_e;
    int   stamp_q [$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_res = 0;
    int   cyc   = 0;

    logic [31:0] bp_a [4] = '{32'h0000_0005, 32'h0000_0003, 32'h0000_0009, 32'hFFFF_0000};
    logic [31:0] bp_b [4] = '{32'h0000_0003, 32'h0000_0005, 32'h0000_0009, 32'hFFFF_0001};
    logic [2:0]  bp_f [4] = '{CMP_GT, CMP_LT, CMP_EQ, CMP_LT};

    comparator_pipe #(.WIDTH(32), .CHUNK(8), .TAG_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef CMP_SIGNED_EN
        .is_signed (is_signed),
`endif
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_gt_b    (a_gt_b),
        .a_eq_b    (a_eq_b),
        .a_lt_b    (a_lt_b),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            check("onehot", 32'($countones({a_gt_b, a_eq_b, a_lt_b})), 32'd1);
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("flags", 32'({a_gt_b, a_eq_b, a_lt_b}), 32'(mon_e.f));
                check("tag", 32'(out_tag), 32'(mon_e.t));
            end
            n_res++;
            stamp_q.push_back(cyc);
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge, in_valid left high.
    task automatic push_op(input logic [31:0] ia, input logic [31:0] ib, input logic is,
                           input logic [3:0] it, input logic [2:0] ef);
        int  w    = 0;
        bit  done = 1'b0;
        a = ia;
        b = ib;
        in_tag = it;
`ifdef CMP_SIGNED_EN
        is_signed = is;
`else
        if (is) a = ia;
`endif
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back('{ef, it});
                done = 1'b1;
            end else if (++w > 50) begin
                check("push_timeout", 32'd0, 32'd1);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int w = 0;
        while ((exp_q.size() != 0 || out_valid) && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (w >= 50) check("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int idx;
        int c0;
        int snap;

        // Reset held with in_valid high must leave everything cleared.
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = 32'h1;
        b        = 32'h0;
        in_tag   = 4'hA;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_flags", 32'({a_gt_b, a_eq_b, a_lt_b}), 32'd0);
        check("rst_tag", 32'(out_tag), 32'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Unsigned, free-flowing output; first op also checks the 2-cycle latency.
        out_ready = 1'b1;
        push_op(32'h0000_0100, 32'h0000_00FF, 1'b0, 4'd3, CMP_GT);
        idle();
        check("lat_cycle1_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("lat_cycle2_valid", 32'(out_valid), 32'd1);
        wait_drain();
        push_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 4'd5, CMP_EQ);
        push_op(32'h0100_0000, 32'h00FF_FFFF, 1'b0, 4'd6, CMP_GT);
        push_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 4'd7, CMP_LT);
        push_op(32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 4'd8, CMP_LT);
        push_op(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 4'd9, CMP_GT);
        push_op(32'h1234_5678, 32'h1234_5679, 1'b0, 4'd10, CMP_LT);
        push_op(32'h0001_0000, 32'h0000_FFFF, 1'b0, 4'd11, CMP_GT);
        idle();
        wait_drain();

`ifdef CMP_SIGNED_EN
        push_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 4'd1, CMP_LT);
        push_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 4'd2, CMP_GT);
        push_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 4'd3, CMP_LT);
        push_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 4'd4, CMP_GT);
        push_op(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 4'd5, CMP_LT);
        idle();
        wait_drain();
`endif

        // Backpressure: out_ready low for 5 cycles, only two ops fit.
        out_ready = 1'b0;
        idx       = 0;
        a         = bp_a[0];
        b         = bp_b[0];
        in_tag    = 4'd0;
        in_valid  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (in_ready && idx < 4) begin
                exp_q.push_back('{bp_f[idx], 4'(idx)});
                idx++;
            end
            @(posedge clk);
            #1;
            if (idx < 4) begin
                a      = bp_a[idx];
                b      = bp_b[idx];
                in_tag = 4'(idx);
            end else begin
                in_valid = 1'b0;
            end
        end
        check("bp_accepts", 32'(idx), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_hold_tag", 32'(out_tag), 32'd0);
        check("bp_hold_flags", 32'({a_gt_b, a_eq_b, a_lt_b}), 32'(CMP_GT));
        out_ready = 1'b1;
        snap      = n_res;
        while (idx < 4) begin
            push_op(bp_a[idx], bp_b[idx], 1'b0, 4'(idx), bp_f[idx]);
            idx++;
        end
        idle();
        wait_drain();
        check("bp_results", 32'(n_res - snap), 32'd4);

        // Full rate: 8 accepts in 8 cycles, 8 results on consecutive cycles.
        stamp_q.delete();
        c0 = cyc;
        for (int i = 0; i < 8; i++)
            push_op(32'(i * 3), 32'd9, 1'b0, 4'(i), (i * 3 > 9) ? CMP_GT : (i * 3 == 9) ? CMP_EQ : CMP_LT);
        idle();
        check("fr_accept_cycles", 32'(cyc - c0), 32'd8);
        wait_drain();
        check("fr_result_count", 32'(stamp_q.size()), 32'd8);
        if (stamp_q.size() >= 8)
            check("fr_result_span", 32'(stamp_q[7] - stamp_q[0]), 32'd7);

        // Mid-stream reset drops in-flight ops.
        push_op(32'h10, 32'h20, 1'b0, 4'd10, CMP_LT);
        push_op(32'h30, 32'h20, 1'b0, 4'd11, CMP_GT);
        push_op(32'h20, 32'h20, 1'b0, 4'd12, CMP_EQ);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_flags", 32'({a_gt_b, a_eq_b, a_lt_b}), 32'd0);
        exp_q.delete();
        snap  = n_res;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("mrst_no_stale", 32'(n_res - snap), 32'd0);
        push_op(32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 4'd13, CMP_EQ);
        idle();
        wait_drain();
        check("mrst_recover", 32'(n_res - snap), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
